cache_refill_alloc: RTL and testbench
=====================================

# cache_refill_alloc

Miss-handling and refill allocator for the set-associative cache, sitting directly upstream of the tree-LRU block. It accepts one miss at a time and selects a victim way: the lowest invalid way if any, else the LRU way. It requests writeback of dirty victims, fetches the line from memory beat by beat, writes it into the data array, then issues the single LRU update for the filled way. It also forwards hit-side LRU updates when idle, making it the sole driver of the LRU read/update ports.

## Interface
- ASSOCIATIVITY, 4: ways; power of two, ≥4.
- ENTRIES, 256: sets.
- INDEX_BITS, 8: set index width.
- OUTPUT_BITS, 2: way index width, log2(ASSOCIATIVITY).
- ADDR_W, 32: byte address width.
- DATA_W, 32: beat width.
- BEATS, 4: beats per line, power of two ≥2. localparam OFF = log2(BEATS·DATA_W/8); index = addr[OFF+INDEX_BITS-1:OFF].

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- miss_valid / miss_ready  in/out  1  miss handshake.
- miss_addr  in  ADDR_W  missing byte address.
- hit_update  in  1  hit-side LRU touch request.
- hit_index  in  INDEX_BITS  set of the hit.
- hit_way  in  OUTPUT_BITS  way of the hit.
- valid_bits, dirty_bits  in  ASSOCIATIVITY  tag-array state of set line_selector, valid in LOOKUP.
- line_selector  out  INDEX_BITS  set index to the LRU and tag arrays.
- lru_way  in  OUTPUT_BITS  LRU way of line_selector (combinational).
- lru_update  out  1  LRU update strobe.
- referenced_set  out  OUTPUT_BITS  way being touched.
- wb_valid / wb_ready  out/in  1  victim writeback handshake.
- wb_index  out  INDEX_BITS  victim set.
- wb_way  out  OUTPUT_BITS  victim way.
- mem_req_valid / mem_req_ready  out/in  1  line fetch handshake.
- mem_req_addr  out  ADDR_W  line-aligned address, low OFF bits 0.
- mem_rsp_valid  in  1  beat valid.
- mem_rsp_data  in  DATA_W  beat data.
- fill_we  out  1  data-array write.
- fill_index  out  INDEX_BITS  write set.
- fill_way  out  OUTPUT_BITS  write way.
- fill_beat  out  log2(BEATS)  write beat.
- fill_data  out  DATA_W  write data.
- fill_done  out  1  one-cycle refill-complete pulse.

## Operation
- States: IDLE, LOOKUP, WRITEBACK, REQUEST, FILL, UPDATE.
- IDLE: miss_ready=1.
  - If hit_update: line_selector=hit_index, lru_update=1, referenced_set=hit_way (combinational, same cycle).
  - If miss_valid: latch miss_addr, register index into line_selector, go LOOKUP. A simultaneous hit_update is still forwarded that cycle.
- LOOKUP (exactly 1 cycle): victim = lowest i with valid_bits[i]=0; if all valid, victim = lru_way. Register victim.
  - victim valid and dirty → WRITEBACK; else → REQUEST.
- WRITEBACK: wb_valid=1 with wb_index/wb_way stable; on wb_ready → REQUEST.
- REQUEST: mem_req_valid=1, addr stable; on mem_req_ready → FILL, beat counter=0.
- FILL: each cycle with mem_rsp_valid:
  - fill_we=1 same cycle; fill_data=mem_rsp_data, fill_beat=counter, fill_index/fill_way=latched.
  - Counter +1. On beat BEATS-1 → UPDATE; counter wraps to 0.
- UPDATE (1 cycle): lru_update=1, referenced_set=victim, line_selector=latched index, fill_done=1 → IDLE.
- line_selector holds the latched index in all non-IDLE states and holds its last value in IDLE without hit_update.
- Ignored inputs:
  - mem_rsp_valid outside FILL.
  - miss_valid outside IDLE.
  - hit_update outside IDLE (blocking cache; bench asserts it never occurs).
- Reset, async, any state: state=IDLE, counter=0, latched addr/victim/line_selector=0. All strobes/valids 0; miss_ready=1 once rst_n is high. An in-flight refill is abandoned; later stray beats are ignored.

## Timing
- Miss accepted at edge T. LOOKUP in cycle T+1. REQUEST earliest T+2.
- With zero-wait ready and back-to-back beats: FILL T+3..T+2+BEATS, UPDATE/fill_done T+3+BEATS.
- A dirty victim adds ≥1 cycle (WRITEBACK).
- The next miss is accepted at the earliest the cycle after UPDATE.
- Hit LRU updates: 0-cycle pass-through, only in IDLE.

## Test plan
- Clean miss, all ways invalid, addr 0x0000_1230 (BEATS=4, DATA_W=32 → OFF=4, index 0x23) → victim 0; mem_req_addr 0x0000_1230; 4 fill_we at beats 0–3; lru_update with referenced_set=0 at T+7.
- All valid, lru_way=2, dirty_bits=0 → no wb_valid; fill_way=2; referenced_set=2.
- All valid, lru_way=3, dirty_bits[3]=1, wb_ready delayed 3 cycles → wb_valid held 3 cycles with wb_way=3, wb_index stable; mem_req_valid asserted only after the wb handshake.
- Gapped beats (mem_rsp_valid 1,0,0,1,1,0,1) plus a stray beat during REQUEST → exactly 4 writes with beats 0..3; stray ignored.
- IDLE hit_update index 0x10 way 1 with simultaneous miss_valid → lru_update same cycle, line_selector=0x10, referenced_set=1; miss proceeds to LOOKUP.
- rst_n low mid-FILL after 2 beats → all outputs idle immediately; subsequent beats produce no fill_we; a new miss restarts at beat 0.

Source files
------------

// File: rtl/cache_refill_alloc.sv
// Blocking miss handler: picks a victim way, writes back dirty victims, refills the
// line beat by beat, then touches the LRU. Also forwards hit-side LRU touches in IDLE.
module cache_refill_alloc #(
  parameter int ASSOCIATIVITY = 4,
  parameter int ENTRIES       = 256,
  parameter int INDEX_BITS    = 8,
  parameter int OUTPUT_BITS   = 2,
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int BEATS         = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     miss_valid,
  output logic                     miss_ready,
  input  logic [ADDR_W-1:0]        miss_addr,
  input  logic                     hit_update,
  input  logic [INDEX_BITS-1:0]    hit_index,
  input  logic [OUTPUT_BITS-1:0]   hit_way,
  input  logic [ASSOCIATIVITY-1:0] valid_bits,
  input  logic [ASSOCIATIVITY-1:0] dirty_bits,
  output logic [INDEX_BITS-1:0]    line_selector,
  input  logic [OUTPUT_BITS-1:0]   lru_way,
  output logic                     lru_update,
  output logic [OUTPUT_BITS-1:0]   referenced_set,
  output logic                     wb_valid,
  input  logic                     wb_ready,
  output logic [INDEX_BITS-1:0]    wb_index,
  output logic [OUTPUT_BITS-1:0]   wb_way,
  output logic                     mem_req_valid,
  input  logic                     mem_req_ready,
  output logic [ADDR_W-1:0]        mem_req_addr,
  input  logic                     mem_rsp_valid,
  input  logic [DATA_W-1:0]        mem_rsp_data,
  output logic                     fill_we,
  output logic [INDEX_BITS-1:0]    fill_index,
  output logic [OUTPUT_BITS-1:0]   fill_way,
  output logic [$clog2(BEATS)-1:0] fill_beat,
  output logic [DATA_W-1:0]        fill_data,
  output logic                     fill_done
);
  localparam int OFF = $clog2(BEATS * DATA_W / 8);
  localparam int BW  = $clog2(BEATS);

  typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, REQUEST, FILL, UPDATE} state_t;

  state_t                  state, nxt;
  logic [ADDR_W-OFF-1:0]   line_q;
  logic [OUTPUT_BITS-1:0]  victim_q, victim_c;
  logic [INDEX_BITS-1:0]   sel_q;
  logic [BW-1:0]           beat_q;
  logic                    unused_ok;

  // Byte offset within the line never leaves the block.
  assign unused_ok = &{1'b0, miss_addr[OFF-1:0], (ENTRIES == 0)};

  // Lowest invalid way wins; a full set falls back to the LRU way.
  always_comb begin
    victim_c = lru_way;
    for (int i = ASSOCIATIVITY - 1; i >= 0; i--)
      if (!valid_bits[i]) victim_c = OUTPUT_BITS'(i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      line_q   <= '0;
      victim_q <= '0;
      sel_q    <= '0;
      beat_q   <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE) begin
        if (miss_valid) begin
          line_q <= miss_addr[ADDR_W-1:OFF];
          sel_q  <= miss_addr[OFF +: INDEX_BITS];
        end else if (hit_update) begin
          sel_q  <= hit_index;
        end
      end
      if (state == LOOKUP)  victim_q <= victim_c;
      if (state == REQUEST) beat_q   <= '0;
      if (fill_we)          beat_q   <= beat_q + BW'(1);
    end
  end

  always_comb begin
    nxt            = state;
    miss_ready     = 1'b0;
    lru_update     = 1'b0;
    referenced_set = victim_q;
    line_selector  = sel_q;
    wb_valid       = 1'b0;
    mem_req_valid  = 1'b0;
    fill_we        = 1'b0;
    fill_done      = 1'b0;
    case (state)
      IDLE: begin
        miss_ready = rst_n;
        // Hit touches bypass the registers so the LRU sees them the same cycle.
        if (hit_update && rst_n) begin
          lru_update     = 1'b1;
          referenced_set = hit_way;
          line_selector  = hit_index;
        end
        if (miss_valid) nxt = LOOKUP;
      end
      LOOKUP:
        nxt = (valid_bits[victim_c] && dirty_bits[victim_c]) ? WRITEBACK : REQUEST;
      WRITEBACK: begin
        wb_valid = 1'b1;
        if (wb_ready) nxt = REQUEST;
      end
      REQUEST: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) nxt = FILL;
      end
      FILL: begin
        fill_we = mem_rsp_valid;
        if (mem_rsp_valid && beat_q == BW'(BEATS - 1)) nxt = UPDATE;
      end
      UPDATE: begin
        lru_update = 1'b1;
        fill_done  = 1'b1;
        nxt        = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  assign wb_index     = sel_q;
  assign wb_way       = victim_q;
  assign mem_req_addr = {line_q, {OFF{1'b0}}};
  assign fill_index   = sel_q;
  assign fill_way     = victim_q;
  assign fill_beat    = beat_q;
  assign fill_data    = mem_rsp_data;
endmodule

// File: tb/tb_cache_refill_alloc.sv
// Bench for cache_refill_alloc: directed scenarios plus randomized misses checked
// against a transaction-level model of victim choice, writeback and beat delivery.
module tb_cache_refill_alloc;
  localparam int A = 4, IB = 8, OB = 2, AW = 32, DW = 32, BEATS = 4, OFF = 4;

  logic clk = 1'b0, rst_n = 1'b0;
  logic miss_valid = 0, miss_ready, hit_update = 0, lru_update, wb_valid, wb_ready = 0;
  logic mem_req_valid, mem_req_ready = 0, mem_rsp_valid = 0, fill_we, fill_done;
  logic [AW-1:0] miss_addr = '0, mem_req_addr;
  logic [IB-1:0] hit_index = '0, line_selector, wb_index, fill_index;
  logic [OB-1:0] hit_way = '0, lru_way = '0, referenced_set, wb_way, fill_way;
  logic [A-1:0]  valid_bits = '0, dirty_bits = '0;
  logic [DW-1:0] mem_rsp_data = '0, fill_data;
  logic [1:0]    fill_beat;

  always #5 clk = ~clk;

  cache_refill_alloc dut (
    .clk(clk), .rst_n(rst_n), .miss_valid(miss_valid), .miss_ready(miss_ready),
    .miss_addr(miss_addr), .hit_update(hit_update), .hit_index(hit_index), .hit_way(hit_way),
    .valid_bits(valid_bits), .dirty_bits(dirty_bits), .line_selector(line_selector),
    .lru_way(lru_way), .lru_update(lru_update), .referenced_set(referenced_set),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_index(wb_index), .wb_way(wb_way),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .fill_we(fill_we),
    .fill_index(fill_index), .fill_way(fill_way), .fill_beat(fill_beat),
    .fill_data(fill_data), .fill_done(fill_done)
  );

  int checks = 0, failures = 0;

  // Observations from one miss transaction (cycle 0 = accept cycle).
  int o_wb_cycles, o_wb_hs_cyc, o_req_first_cyc, o_done_cyc, e_done_cyc, o_lru_cnt;
  logic o_acc_ready, o_acc_lru, o_wb_unstable, o_req_unstable, o_fill_mixed, o_ready_after, o_timeout;
  logic [IB-1:0] o_acc_sel, o_look_sel, o_wb_idx, o_done_sel, o_fidx;
  logic [OB-1:0] o_acc_ref, o_wb_way, o_done_ref, o_fway;
  logic [AW-1:0] o_req_addr;
  logic [1:0]    o_fbeat[$];
  logic [DW-1:0] o_fdata[$], e_fdata[$];

  // Reference model: pure rules, no notion of the DUT's states.
  function automatic logic [OB-1:0] m_victim(logic [A-1:0] v, logic [OB-1:0] lru);
    for (int i = 0; i < A; i++) if (!v[i]) return OB'(i);
    return lru;
  endfunction
  function automatic bit m_wb(logic [A-1:0] v, logic [A-1:0] d, logic [OB-1:0] lru);
    return (v == {A{1'b1}}) && d[lru];
  endfunction
  function automatic logic [IB-1:0] m_index(logic [AW-1:0] a);
    return IB'(a / (BEATS * DW / 8));
  endfunction
  function automatic logic [AW-1:0] m_line(logic [AW-1:0] a);
    return a - (a % (BEATS * DW / 8));
  endfunction
  function automatic bit beats_ok();
    if (o_fbeat.size() != BEATS) return 0;
    for (int i = 0; i < BEATS; i++) if (o_fbeat[i] !== 2'(i)) return 0;
    return 1;
  endfunction
  function automatic bit data_ok();
    if (o_fdata.size() != BEATS || e_fdata.size() != BEATS) return 0;
    for (int i = 0; i < BEATS; i++) if (o_fdata[i] !== e_fdata[i]) return 0;
    return 1;
  endfunction

  // Hit touches must only ever be driven while the block is idle.
  always @(posedge clk)
    if (rst_n && hit_update && !miss_ready) begin
      failures++;
      $display("FAIL hit_outside_idle got miss_ready=%0b exp=1", miss_ready);
    end

  // Drives one miss end to end and records what the DUT did; callers compare.
  task automatic run_miss(input logic [AW-1:0] addr, input logic [A-1:0] v, input logic [A-1:0] d,
                          input logic [OB-1:0] lru, input int wb_d, input int req_d, input int gap,
                          input bit stray, input bit hit, input logic [IB-1:0] hidx,
                          input logic [OB-1:0] hway);
    int cyc, wb_seen, req_seen, pidx;
    bit req_done, done, hs_now;
    int pat[7] = '{1, 0, 0, 1, 1, 0, 1};
    cyc = 0; wb_seen = 0; req_seen = 0; pidx = 0; req_done = 0; done = 0;
    o_wb_hs_cyc = -1; o_req_first_cyc = -1; o_done_cyc = -1; e_done_cyc = -2; o_lru_cnt = 0;
    o_wb_unstable = 0; o_req_unstable = 0; o_fill_mixed = 0; o_ready_after = 0; o_timeout = 1;
    o_look_sel = 'x; o_fidx = 'x; o_fway = 'x; o_done_ref = 'x; o_done_sel = 'x; o_req_addr = 'x;
    o_wb_way = 'x; o_wb_idx = 'x;
    o_fbeat.delete(); o_fdata.delete(); e_fdata.delete();
    @(negedge clk);
    miss_valid = 1; miss_addr = addr; valid_bits = v; dirty_bits = d; lru_way = lru;
    hit_update = hit; hit_index = hidx; hit_way = hway;
    wb_ready = 0; mem_req_ready = 0; mem_rsp_valid = 0;
    #1;
    o_acc_ready = miss_ready; o_acc_lru = lru_update; o_acc_sel = line_selector; o_acc_ref = referenced_set;
    while (cyc < 300) begin
      @(negedge clk);
      cyc++;
      miss_valid = 0; hit_update = 0; miss_addr = $urandom;
      if (done) begin
        #1 o_ready_after = miss_ready;
        o_timeout = 0;
        break;
      end
      wb_ready = (wb_seen + 1 >= wb_d);
      mem_req_ready = (req_seen + 1 >= req_d);
      if (!req_done) mem_rsp_valid = stray;
      else if (gap == 0) mem_rsp_valid = 1;
      else if (gap == 1) begin mem_rsp_valid = (pidx < 7) ? pat[pidx][0] : 1'b1; pidx++; end
      else mem_rsp_valid = 1'($urandom % 2);
      mem_rsp_data = $urandom;
      #1;
      hs_now = 0;
      if (cyc == 1) o_look_sel = line_selector;
      if (wb_valid) begin
        if (wb_seen == 0) begin o_wb_way = wb_way; o_wb_idx = wb_index; end
        else if (wb_way !== o_wb_way || wb_index !== o_wb_idx) o_wb_unstable = 1;
        wb_seen++;
        if (wb_ready) o_wb_hs_cyc = cyc;
      end
      if (mem_req_valid) begin
        if (req_seen == 0) begin o_req_first_cyc = cyc; o_req_addr = mem_req_addr; end
        else if (mem_req_addr !== o_req_addr) o_req_unstable = 1;
        req_seen++;
        if (mem_req_ready) hs_now = 1;
      end
      if (fill_we) begin
        o_fbeat.push_back(fill_beat); o_fdata.push_back(fill_data);
        if (o_fbeat.size() == 1) begin o_fidx = fill_index; o_fway = fill_way; end
        else if (fill_index !== o_fidx || fill_way !== o_fway) o_fill_mixed = 1;
      end
      if (req_done && mem_rsp_valid && e_fdata.size() < BEATS) begin
        e_fdata.push_back(mem_rsp_data);
        if (e_fdata.size() == BEATS) e_done_cyc = cyc + 1;
      end
      if (hs_now) req_done = 1;
      if (lru_update) o_lru_cnt++;
      if (fill_done) begin
        done = 1; o_done_cyc = cyc; o_done_ref = referenced_set; o_done_sel = line_selector;
      end
    end
    o_wb_cycles = wb_seen;
    mem_rsp_valid = 0; wb_ready = 0; mem_req_ready = 0;
  endtask

  task automatic test_reset();
    mem_rsp_valid = 1; hit_update = 1; hit_index = 8'h5A;
    #12;
    checks++; if ({lru_update, fill_we, wb_valid, mem_req_valid, fill_done} !== 5'b0) begin
      failures++; $display("FAIL reset_strobes got=%b exp=00000", {lru_update, fill_we, wb_valid, mem_req_valid, fill_done}); end
    @(negedge clk); mem_rsp_valid = 0; hit_update = 0; rst_n = 1;
    #1;
    checks++; if (miss_ready !== 1'b1) begin failures++; $display("FAIL reset_miss_ready got=%b exp=1", miss_ready); end
    checks++; if (line_selector !== 8'h00) begin failures++; $display("FAIL reset_line_selector got=%h exp=00", line_selector); end
    checks++; if (lru_update !== 1'b0) begin failures++; $display("FAIL reset_lru_update got=%b exp=0", lru_update); end
  endtask

  task automatic test_clean_miss();
    run_miss(32'h0000_1230, 4'h0, 4'hF, 2'd3, 1, 1, 0, 0, 0, '0, '0);
    checks++; if (o_timeout !== 1'b0) begin failures++; $display("FAIL clean_timeout got=%b exp=0", o_timeout); end
    checks++; if (o_acc_ready !== 1'b1) begin failures++; $display("FAIL clean_accept_ready got=%b exp=1", o_acc_ready); end
    checks++; if (o_look_sel !== 8'h23) begin failures++; $display("FAIL clean_lookup_sel got=%h exp=23", o_look_sel); end
    checks++; if (o_wb_cycles !== 0) begin failures++; $display("FAIL clean_no_wb got=%0d exp=0", o_wb_cycles); end
    checks++; if (o_req_addr !== 32'h0000_1230) begin failures++; $display("FAIL clean_req_addr got=%h exp=00001230", o_req_addr); end
    checks++; if (o_req_first_cyc !== 2) begin failures++; $display("FAIL clean_req_cycle got=%0d exp=2", o_req_first_cyc); end
    checks++; if (!beats_ok()) begin failures++; $display("FAIL clean_beats got=%0d writes exp=%0d in order", o_fbeat.size(), BEATS); end
    checks++; if (!data_ok()) begin failures++; $display("FAIL clean_data got=%0d words exp=%0d matching", o_fdata.size(), BEATS); end
    checks++; if (o_fway !== 2'd0 || o_fidx !== 8'h23) begin failures++; $display("FAIL clean_fill_loc got=%h/%0d exp=23/0", o_fidx, o_fway); end
    checks++; if (o_done_cyc !== 3 + BEATS) begin failures++; $display("FAIL clean_done_cycle got=%0d exp=%0d", o_done_cyc, 3 + BEATS); end
    checks++; if (o_done_ref !== 2'd0 || o_done_sel !== 8'h23) begin failures++; $display("FAIL clean_update got=%0d/%h exp=0/23", o_done_ref, o_done_sel); end
    checks++; if (o_ready_after !== 1'b1) begin failures++; $display("FAIL clean_ready_after got=%b exp=1", o_ready_after); end
  endtask

  task automatic test_lru_clean();
    run_miss(32'h0000_ABC0, 4'hF, 4'h0, 2'd2, 1, 1, 0, 0, 0, '0, '0);
    checks++; if (o_wb_cycles !== 0) begin failures++; $display("FAIL lru_no_wb got=%0d exp=0", o_wb_cycles); end
    checks++; if (o_fway !== 2'd2) begin failures++; $display("FAIL lru_fill_way got=%0d exp=2", o_fway); end
    checks++; if (o_done_ref !== 2'd2) begin failures++; $display("FAIL lru_ref got=%0d exp=2", o_done_ref); end
  endtask

  task automatic test_dirty_wb();
    run_miss(32'h0001_2340, 4'hF, 4'h8, 2'd3, 3, 1, 0, 0, 0, '0, '0);
    checks++; if (o_wb_cycles !== 3) begin failures++; $display("FAIL wb_cycles got=%0d exp=3", o_wb_cycles); end
    checks++; if (o_wb_way !== 2'd3 || o_wb_idx !== 8'h34) begin failures++; $display("FAIL wb_target got=%h/%0d exp=34/3", o_wb_idx, o_wb_way); end
    checks++; if (o_wb_unstable !== 1'b0) begin failures++; $display("FAIL wb_stable got=%b exp=0", o_wb_unstable); end
    checks++; if (o_req_first_cyc !== o_wb_hs_cyc + 1) begin failures++; $display("FAIL wb_then_req got=%0d exp=%0d", o_req_first_cyc, o_wb_hs_cyc + 1); end
    checks++; if (o_done_cyc !== 6 + BEATS) begin failures++; $display("FAIL wb_done_cycle got=%0d exp=%0d", o_done_cyc, 6 + BEATS); end
  endtask

  task automatic test_gapped_beats();
    run_miss(32'h0000_0770, 4'h3, 4'hF, 2'd0, 1, 3, 1, 1, 0, '0, '0);
    checks++; if (!beats_ok()) begin failures++; $display("FAIL gap_beats got=%0d writes exp=%0d in order", o_fbeat.size(), BEATS); end
    checks++; if (!data_ok()) begin failures++; $display("FAIL gap_data got=%0d words exp=%0d matching", o_fdata.size(), BEATS); end
    checks++; if (o_fway !== 2'd2) begin failures++; $display("FAIL gap_fill_way got=%0d exp=2", o_fway); end
    checks++; if (o_done_cyc !== e_done_cyc) begin failures++; $display("FAIL gap_done_cycle got=%0d exp=%0d", o_done_cyc, e_done_cyc); end
  endtask

  task automatic test_hit_miss();
    @(negedge clk);
    hit_update = 1; hit_index = 8'h44; hit_way = 2'd3;
    #1;
    checks++; if ({lru_update, line_selector, referenced_set} !== {1'b1, 8'h44, 2'd3}) begin failures++;
      $display("FAIL hit_passthru got=%b/%h/%0d exp=1/44/3", lru_update, line_selector, referenced_set); end
    @(negedge clk); hit_update = 0;
    #1;
    checks++; if (lru_update !== 1'b0 || line_selector !== 8'h44) begin failures++;
      $display("FAIL hit_hold got=%b/%h exp=0/44", lru_update, line_selector); end
    run_miss(32'h0000_0560, 4'h0, 4'h0, 2'd0, 1, 1, 0, 0, 1, 8'h10, 2'd1);
    checks++; if ({o_acc_lru, o_acc_sel, o_acc_ref} !== {1'b1, 8'h10, 2'd1}) begin failures++;
      $display("FAIL hit_with_miss got=%b/%h/%0d exp=1/10/1", o_acc_lru, o_acc_sel, o_acc_ref); end
    checks++; if (o_look_sel !== 8'h56) begin failures++; $display("FAIL hit_miss_lookup got=%h exp=56", o_look_sel); end
    checks++; if (o_done_cyc !== 3 + BEATS) begin failures++; $display("FAIL hit_miss_done got=%0d exp=%0d", o_done_cyc, 3 + BEATS); end
  endtask

  task automatic test_reset_mid_fill();
    int n = 0, stray = 0;
    @(negedge clk);
    miss_valid = 1; miss_addr = 32'h0000_5670; valid_bits = 4'h0; dirty_bits = 4'h0;
    for (int c = 0; c < 40 && n < 2; c++) begin
      @(negedge clk);
      miss_valid = 0; mem_req_ready = 1; mem_rsp_valid = 1; mem_rsp_data = $urandom;
      #1 if (fill_we) n++;
    end
    checks++; if (n !== 2) begin failures++; $display("FAIL rst_fill_reached got=%0d exp=2", n); end
    @(posedge clk); #2 rst_n = 0;
    #1;
    checks++; if ({fill_we, wb_valid, mem_req_valid, lru_update, fill_done, line_selector} !== 13'b0) begin failures++;
      $display("FAIL rst_idle_outputs got=%b exp=0", {fill_we, wb_valid, mem_req_valid, lru_update, fill_done, line_selector}); end
    @(negedge clk); rst_n = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); mem_rsp_valid = 1; mem_rsp_data = $urandom;
      #1 if (fill_we) stray++;
    end
    checks++; if (stray !== 0) begin failures++; $display("FAIL rst_stray_beats got=%0d exp=0", stray); end
    mem_rsp_valid = 0; mem_req_ready = 0;
    run_miss(32'h0000_5670, 4'h0, 4'h0, 2'd0, 1, 1, 0, 0, 0, '0, '0);
    checks++; if (!beats_ok()) begin failures++; $display("FAIL rst_restart_beats got=%0d writes exp=%0d in order", o_fbeat.size(), BEATS); end
    checks++; if (o_done_cyc !== 3 + BEATS) begin failures++; $display("FAIL rst_restart_done got=%0d exp=%0d", o_done_cyc, 3 + BEATS); end
  endtask

  task automatic test_random();
    logic [AW-1:0] addr; logic [A-1:0] v, d; logic [OB-1:0] lru, ev; logic [IB-1:0] idx;
    int wb_d, req_d; bit ewb, stray;
    for (int it = 0; it < 24; it++) begin
      addr = $urandom; v = ($urandom % 2) ? 4'hF : 4'($urandom); d = 4'($urandom); lru = 2'($urandom);
      wb_d = 1 + $urandom % 3; req_d = 1 + $urandom % 3; stray = 1'($urandom % 2);
      ev = m_victim(v, lru); ewb = m_wb(v, d, lru); idx = m_index(addr);
      run_miss(addr, v, d, lru, wb_d, req_d, 2, stray, 0, '0, '0);
      checks++; if (o_timeout !== 1'b0) begin failures++; $display("FAIL rnd%0d_timeout got=%b exp=0", it, o_timeout); end
      checks++; if (o_look_sel !== idx) begin failures++; $display("FAIL rnd%0d_lookup_sel got=%h exp=%h", it, o_look_sel, idx); end
      checks++; if (o_wb_cycles !== (ewb ? wb_d : 0)) begin failures++; $display("FAIL rnd%0d_wb_cycles got=%0d exp=%0d", it, o_wb_cycles, ewb ? wb_d : 0); end
      if (ewb) begin
        checks++; if (o_wb_way !== ev || o_wb_idx !== idx || o_wb_unstable) begin failures++;
          $display("FAIL rnd%0d_wb_target got=%h/%0d exp=%h/%0d", it, o_wb_idx, o_wb_way, idx, ev); end
      end
      checks++; if (o_req_addr !== m_line(addr) || o_req_unstable) begin failures++; $display("FAIL rnd%0d_req_addr got=%h exp=%h", it, o_req_addr, m_line(addr)); end
      checks++; if (o_req_first_cyc !== (ewb ? 2 + wb_d : 2)) begin failures++; $display("FAIL rnd%0d_req_cycle got=%0d exp=%0d", it, o_req_first_cyc, ewb ? 2 + wb_d : 2); end
      checks++; if (!beats_ok() || !data_ok()) begin failures++; $display("FAIL rnd%0d_fill got=%0d writes exp=%0d matching", it, o_fbeat.size(), BEATS); end
      checks++; if (o_fway !== ev || o_fidx !== idx || o_fill_mixed) begin failures++; $display("FAIL rnd%0d_fill_loc got=%h/%0d exp=%h/%0d", it, o_fidx, o_fway, idx, ev); end
      checks++; if (o_done_cyc !== e_done_cyc) begin failures++; $display("FAIL rnd%0d_done_cycle got=%0d exp=%0d", it, o_done_cyc, e_done_cyc); end
      checks++; if (o_done_ref !== ev || o_done_sel !== idx || o_lru_cnt !== 1) begin failures++;
        $display("FAIL rnd%0d_update got=%0d/%h/%0d exp=%0d/%h/1", it, o_done_ref, o_done_sel, o_lru_cnt, ev, idx); end
      checks++; if (o_ready_after !== 1'b1) begin failures++; $display("FAIL rnd%0d_ready_after got=%b exp=1", it, o_ready_after); end
    end
  endtask

  initial begin
    test_reset();
    test_clean_miss();
    test_lru_clean();
    test_dirty_wb();
    test_gapped_beats();
    test_hit_miss();
    test_reset_mid_fill();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
